// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALTED control, redirect/trap
// selection, valid/ready handshake and a saturating accepted-fetch counter.
// Optional misaligned-redirect trapping is enabled with PC_GEN_MISALIGN_TRAP_EN.
module pc_gen #(
    parameter int unsigned         XLEN        = 32,
    parameter logic [XLEN-1:0]     RESET_VEC   = 32'hBFC0_0000,
    parameter logic [XLEN-1:0]     TRAP_VEC    = 32'hBFC0_0380,
    parameter int unsigned         INSTR_BYTES = 4,
    parameter int unsigned         BOOT_CYCLES = 1,
    parameter int unsigned         COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    input  logic               trap_req,
    input  logic               halt_req,
    input  logic               resume,
    output logic [XLEN-1:0]    pc,
    output logic               pc_valid,
    output logic [XLEN-1:0]    pc_plus,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count,
    output logic               misalign_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [3:0]      BOOT_LAST  = 4'(BOOT_CYCLES - 1);

    state_t          state, state_next;
    logic [3:0]      boot_cnt, boot_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_pc;
    logic            misaligned;
    logic            redirect_take;
    logic            fire;

    assign pc_valid = (state == RUN);
    assign halted   = (state == HALTED);
    assign pc_plus  = pc + XLEN'(INSTR_BYTES);
    assign fire     = pc_valid && pc_ready;

    // A redirect only lands when the state accepts it and no trap outranks it.
    assign redirect_take = redirect_valid && !trap_req && (state == RUN || state == HALTED);
    assign misaligned    = |(redirect_target & ~ALIGN_MASK);

`ifdef PC_GEN_MISALIGN_TRAP_EN
    assign redirect_pc = misaligned ? TRAP_VEC : (redirect_target & ALIGN_MASK);
`else
    assign redirect_pc = redirect_target & ALIGN_MASK;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        boot_next  = boot_cnt;
        case (state)
            BOOT: begin
                boot_next = boot_cnt + 4'd1;
                if (boot_cnt == BOOT_LAST) state_next = RUN;
            end
            RUN: begin
                if (trap_req)            pc_next = TRAP_VEC;
                else if (redirect_valid) pc_next = redirect_pc;
                else if (pc_ready)       pc_next = pc_plus;
                if (halt_req && !trap_req) state_next = HALTED;
            end
            HALTED: begin
                if (trap_req) begin
                    pc_next    = TRAP_VEC;
                    state_next = RUN;
                end else if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = RUN;
                end else if (resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            boot_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            boot_cnt <= boot_next;
        end
    end

    // Saturating counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count <= '0;
        else if (fire && (fetch_count != {COUNT_W{1'b1}}))
            fetch_count <= fetch_count + COUNT_W'(1);
    end

`ifdef PC_GEN_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= redirect_take && misaligned;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; the next generation of the plain PC register.
- Holds the PC and computes the PC+step (PCPlus4) value.
- Selects PCNext from trap, redirect (PCTarget) or sequential sources.
- Adds a fetch valid/ready handshake, stall/halt control, a boot delay and an accepted-fetch counter. Feeds instruction-memory address and the decode-stage PC pipeline register.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VEC, 32'hBFC0_0000, PC value loaded on reset (instruction memory base).
- TRAP_VEC, 32'hBFC0_0380, PC loaded on trap_req.
- INSTR_BYTES, 4, sequential increment; power of two, 2 or 4.
- BOOT_CYCLES, 1, cycles pc_valid stays low after reset release; 1..15.
- COUNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_ready  in  1  fetch stage accepts pc this cycle
- redirect_valid  in  1  branch/jump resolved taken
- redirect_target  in  XLEN  PCTarget
- trap_req  in  1  exception/interrupt redirect
- halt_req  in  1  request to stop fetching
- resume  in  1  leave HALTED at current pc
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc is a real fetch request
- pc_plus  out  XLEN  pc + INSTR_BYTES, combinational, wraps mod 2^XLEN
- halted  out  1  high in HALTED state
- fetch_count  out  COUNT_W  number of accepted fetches (pc_valid && pc_ready)
- misalign_err  out  1  one-cycle pulse, see Optional Feature

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On a rising clk edge with rst=1: pc=RESET_VEC, state=BOOT, boot counter=0, fetch_count=0, misalign_err=0.
  - Outputs during and immediately after reset: pc_valid=0, halted=0.
  - rst overrides all other inputs, in any state, mid-handshake included.
- States: BOOT, RUN, HALTED.
- BOOT:
  - pc_valid=0; pc holds RESET_VEC.
  - Counter increments each cycle; after BOOT_CYCLES cycles -> RUN.
  - redirect/trap/halt inputs are ignored in BOOT.
- RUN:
  - pc_valid=1.
  - Next-PC priority, registered, 1-cycle latency:
    1. trap_req: pc<=TRAP_VEC
    2. redirect_valid: pc<=redirect_target with low log2(INSTR_BYTES) bits cleared
    3. pc_ready: pc<=pc_plus
    4. else hold
  - A redirect or trap in the same cycle as an accepted fetch still counts that fetch; the new pc is presented next cycle with pc_valid=1, no bubble.
  - pc and pc_valid must be stable while pc_valid=1 and pc_ready=0, unless redirect or trap occurs.
- halt_req in RUN:
  - Takes effect after the current cycle's update (redirect/trap/increment still applied).
  - Next state HALTED.
  - trap_req has priority over halt_req: trap applies and state stays RUN.
- HALTED:
  - pc_valid=0, halted=1, pc holds, fetch_count holds.
  - trap_req -> pc<=TRAP_VEC, RUN.
  - redirect_valid -> pc<=target, RUN.
  - resume -> RUN at held pc.
  - halt_req while HALTED: no effect.
- fetch_count:
  - +1 per cycle with pc_valid && pc_ready.
  - Saturates at all-ones; never wraps.
- Wrap-around: pc = 2^XLEN - INSTR_BYTES increments to 0 with no error.

Optional Feature:
- Macro PC_GEN_MISALIGN_TRAP_EN.
- Defined:
  - A redirect_valid whose target has nonzero low log2(INSTR_BYTES) bits loads TRAP_VEC instead of the target.
  - misalign_err pulses high for the cycle after the redirect.
  - The check applies in RUN and HALTED; a misaligned redirect from HALTED still exits to RUN.
- Undefined: low bits are silently cleared; misalign_err is tied 0.

Test Plan:
- Reset release, BOOT_CYCLES=1, pc_ready=1 -> pc=BFC0_0000 with pc_valid=0 for 1 cycle, then pc=BFC0_0000, BFC0_0004, BFC0_0008; fetch_count=1,2,3.
- pc_ready=0 for 3 cycles in RUN at BFC0_0010 -> pc held at BFC0_0010, pc_valid=1, fetch_count unchanged.
- Same cycle trap_req=1 and redirect_valid=1 with target 8000_0040 -> next pc=BFC0_0380; redirect dropped.
- halt_req in RUN at BFC0_0020 with pc_ready=1 -> HALTED, pc=BFC0_0024, pc_valid=0, halted=1. resume -> RUN at BFC0_0024.
- Wrap-around: redirect to FFFF_FFFC, then pc_ready=1 -> pc=0000_0000. Separately, rst asserted mid-RUN -> next cycle pc=BFC0_0000, fetch_count=0, pc_valid=0.
- Redirect to BFC0_0102:
  - Macro undefined -> pc=BFC0_0100, misalign_err=0.
  - Macro defined -> pc=BFC0_0380, misalign_err=1 for one cycle.
